// File: rtl/lstm_mac_acc.sv
`timescale 1ns/1ps
// lstm_mac_acc: sequential multiply-accumulate for one LSTM gate element.
// Forms bias + sum(w*x) in signed fixed point (WIDTH bits, FRAC fraction bits)
// over a packet of valid/ready beats. The finished sum is held on the output
// register until the downstream activation stage accepts it.
//
// Optional feature macro: MAC_SAT_EN
//   defined   : product and every addition clamp to max/min signed; o_sat flags it.
//   undefined : product truncates, additions wrap; o_sat is constant 0.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   i_w, i_x      weight / input value for the beat
//   i_bias        bias, sampled only on the first beat of a packet
//   i_last        final beat of the packet
//   i_valid       beat present
//   i_ready       block can accept a beat (depends on state only)
//   o_data        finished pre-activation
//   o_beats       beats in the packet, saturating at all-ones
//   o_sat         a clamp occurred in this packet
//   o_valid       outputs valid
//   o_ready       consumer accepts the output
module lstm_mac_acc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 20,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_w,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_bias,
  input  logic             i_last,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [LEN_W-1:0] o_beats,
  output logic             o_sat,
  output logic             o_valid,
  input  logic             o_ready
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [0:0] {StAcc, StOut} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_first;
  logic [LEN_W-1:0] r_cnt;
  logic             r_sat;
  logic [WIDTH-1:0] r_data;
  logic [LEN_W-1:0] r_beats;
  logic             r_osat;

  logic signed [PW-1:0] w_w_ext;
  logic signed [PW-1:0] w_x_ext;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_shift;
  logic [WIDTH-1:0]     w_base;
  logic [WIDTH-1:0]     w_p;
  logic [WIDTH-1:0]     w_new;
  logic                 w_clamp;
  logic                 w_sticky;
  logic [LEN_W-1:0]     w_cnt;

  // Sign-extend both operands so the full-width product is exact.
  assign w_w_ext = {{WIDTH{i_w[WIDTH-1]}}, i_w};
  assign w_x_ext = {{WIDTH{i_x[WIDTH-1]}}, i_x};
  assign w_prod  = w_w_ext * w_x_ext;
  // Arithmetic shift of a signed value rounds toward minus infinity.
  assign w_shift = w_prod >>> FRAC;

  assign w_base = r_first ? i_bias : r_acc;

`ifdef MAC_SAT_EN
  localparam logic [WIDTH-1:0] MaxVal = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  logic           w_p_ovf;
  logic           w_s_ovf;
  logic [WIDTH:0] w_sum;

  // The shifted product fits only if every bit above WIDTH-2 repeats the sign.
  assign w_p_ovf = (w_shift[PW-1:WIDTH-1] != {(PW-WIDTH+1){w_shift[PW-1]}});
  assign w_p     = w_p_ovf ? (w_shift[PW-1] ? MinVal : MaxVal) : w_shift[WIDTH-1:0];
  assign w_sum   = {w_base[WIDTH-1], w_base} + {w_p[WIDTH-1], w_p};
  assign w_s_ovf = (w_sum[WIDTH] != w_sum[WIDTH-1]);
  assign w_new   = w_s_ovf ? (w_sum[WIDTH] ? MinVal : MaxVal) : w_sum[WIDTH-1:0];
  assign w_clamp = w_p_ovf | w_s_ovf;
`else
  logic unused_shift;

  assign w_p          = w_shift[WIDTH-1:0];
  assign w_new        = w_base + w_p;
  assign w_clamp      = 1'b0;
  assign unused_shift = ^w_shift[PW-1:WIDTH];
`endif

  assign w_sticky = r_sat | w_clamp;
  assign w_cnt    = r_first ? LEN_W'(1) : ((&r_cnt) ? r_cnt : r_cnt + LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StAcc;
      r_acc   <= '0;
      r_first <= 1'b1;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_data  <= '0;
      r_beats <= '0;
      r_osat  <= 1'b0;
    end else begin
      unique case (r_state)
        StAcc: begin
          if (i_valid) begin
            r_acc   <= w_new;
            r_first <= 1'b0;
            r_cnt   <= w_cnt;
            r_sat   <= w_sticky;
            if (i_last) begin
              r_data  <= w_new;
              r_beats <= w_cnt;
              r_osat  <= w_sticky;
              r_state <= StOut;
            end
          end
        end
        StOut: begin
          if (o_ready) begin
            r_state <= StAcc;
            r_first <= 1'b1;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
          end
        end
        default: r_state <= StAcc;
      endcase
    end
  end

  assign i_ready = (r_state == StAcc);
  assign o_valid = (r_state == StOut);
  assign o_data  = r_data;
  assign o_beats = r_beats;
  assign o_sat   = r_osat;

endmodule

// File: tb/tb_lstm_mac_acc.sv
`timescale 1ns/1ps
// Bench for lstm_mac_acc. A second instance with LEN_W=2 runs in lockstep on the
// same inputs so the beat-count cap is exercised on a short packet.
module tb_lstm_mac_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_w, i_x, i_bias;
  logic        i_last, i_valid, i_ready;
  logic [31:0] o_data;
  logic [7:0]  o_beats;
  logic        o_sat, o_valid, o_ready;

  logic        i_ready_c, o_sat_c, o_valid_c;
  logic [31:0] o_data_c;
  logic [1:0]  o_beats_c;

  always #5 clk = ~clk;

  lstm_mac_acc #(.WIDTH(32), .FRAC(20), .LEN_W(8)) u_dut (
    .clk(clk), .rst(rst), .i_w(i_w), .i_x(i_x), .i_bias(i_bias), .i_last(i_last),
    .i_valid(i_valid), .i_ready(i_ready), .o_data(o_data), .o_beats(o_beats),
    .o_sat(o_sat), .o_valid(o_valid), .o_ready(o_ready)
  );

  lstm_mac_acc #(.WIDTH(32), .FRAC(20), .LEN_W(2)) u_cap (
    .clk(clk), .rst(rst), .i_w(i_w), .i_x(i_x), .i_bias(i_bias), .i_last(i_last),
    .i_valid(i_valid), .i_ready(i_ready_c), .o_data(o_data_c), .o_beats(o_beats_c),
    .o_sat(o_sat_c), .o_valid(o_valid_c), .o_ready(o_ready)
  );

  typedef struct {
    logic [31:0] data;
    int          beats;
    int          beats_cap;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  int   qw[$];
  int   qx[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   m_sat;
  bit   rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input int n, input logic s);
    exp_t e;
    e.data      = d;
    e.beats     = (n > 255) ? 255 : n;
    e.beats_cap = (n > 3) ? 3 : n;
    e.sat       = s;
    return e;
  endfunction

  // Reduce an exact value to 32 bits: clamp (flagging it) or wrap.
  function automatic int fit(input longint v);
`ifdef MAC_SAT_EN
    if (v > 64'sd2147483647) begin
      m_sat = 1'b1;
      return 32'h7FFF_FFFF;
    end
    if (v < -64'sd2147483648) begin
      m_sat = 1'b1;
      return int'(32'h8000_0000);
    end
`endif
    return int'(v);
  endfunction

  // Reference: fold bias + floor(w*x / 2^20) over the packet in exact arithmetic.
  function automatic exp_t model(input int bias, input int ws[$], input int xs[$]);
    int acc;
    int p;
    m_sat = 1'b0;
    acc   = bias;
    foreach (ws[i]) begin
      p   = fit((longint'(ws[i]) * longint'(xs[i])) >>> 20);
      acc = fit(longint'(acc) + longint'(p));
    end
    return mk(acc, ws.size(), m_sat);
  endfunction

  function automatic int rnd_val();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 32'h0080_0000)) - 32'h0040_0000;
  endfunction

  task automatic add_beat(input int w, input int x);
    qw.push_back(w);
    qx.push_back(x);
  endtask

  task automatic clear_pkt();
    qw.delete();
    qx.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic beat(input logic [31:0] w, input logic [31:0] x, input logic [31:0] b,
                      input bit last);
    bit ok;
    ok      = 1'b0;
    i_w     = w;
    i_x     = x;
    i_bias  = b;
    i_last  = last;
    i_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (i_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_w     = $urandom;
    i_x     = $urandom;
    i_bias  = $urandom;
    chk("beat_accepted", ok, 1'b1);
    if (ok && last) chk("latency_o_valid", o_valid, 1'b1);
  endtask

  task automatic send_pkt(input int bias, input int ws[$], input int xs[$], input bit gaps);
    for (int i = 0; i < ws.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      beat(ws[i], xs[i], (i == 0) ? bias : $urandom, i == ws.size() - 1);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_o_valid"}, o_valid, 1'b0);
    chk({tag, "_o_data"}, o_data, 32'h0);
    chk({tag, "_o_beats"}, o_beats, 8'h0);
    chk({tag, "_o_sat"}, o_sat, 1'b0);
    chk({tag, "_i_ready"}, i_ready, 1'b1);
    chk({tag, "_cap_beats"}, o_beats_c, 2'h0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Consumer-side ready, randomized only during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) o_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each output handshake.
  initial begin
    logic [31:0] hd;
    logic [7:0]  hb;
    bit          ph;
    exp_t        e;
    ph = 1'b0;
    hd = '0;
    hb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph = 1'b0;
      end else begin
        chk("ready_excl_valid", i_ready ^ o_valid, 1'b1);
        chk("lockstep_valid", o_valid_c, o_valid);
        if (ph) begin
          chk("hold_valid", o_valid, 1'b1);
          chk("hold_data", o_data, hd);
          chk("hold_beats", o_beats, hb);
        end
        if (o_valid && o_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got data %0h with no expected entry", o_data);
          end else begin
            e = sb.pop_front();
            chk("o_data", o_data, e.data);
            chk("o_beats", o_beats, e.beats);
            chk("o_sat", o_sat, e.sat);
            chk("cap_o_beats", o_beats_c, e.beats_cap);
            chk("cap_o_data", o_data_c, e.data);
          end
        end
        ph = o_valid && !o_ready;
        hd = o_data;
        hb = o_beats;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bias;
    int n;
    i_w = '0; i_x = '0; i_bias = '0; i_last = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    // Partial packet discarded by a mid-stream reset.
    o_ready = 1'b1;
    beat(32'h0010_0000, 32'h0030_0000, 32'h0050_0000, 1'b0);
    beat(32'h0020_0000, 32'h0020_0000, 32'h0, 1'b0);
    do_reset("midreset");
    o_ready = 1'b1;
    clear_pkt();
    add_beat(32'h0010_0000, 32'h0010_0000);
    sb.push_back(mk(32'h0014_0000, 1, 1'b0));
    send_pkt(32'h0004_0000, qw, qx, 1'b0);

    // Two-beat sum held under backpressure, then a fresh packet waiting on i_ready.
    @(posedge clk);
    #1;
    o_ready = 1'b0;
    clear_pkt();
    add_beat(32'h0008_0000, 32'h0020_0000);
    add_beat(32'h0010_0000, int'(32'hFFF0_0000));
    sb.push_back(mk(32'h0004_0000, 2, 1'b0));
    send_pkt(32'h0004_0000, qw, qx, 1'b0);
    sb.push_back(mk(32'h0040_0000, 1, 1'b0));
    fork
      beat(32'h0010_0000, 32'h0010_0000, 32'h0030_0000, 1'b1);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_i_ready", i_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        o_ready = 1'b1;
      end
    join

    // Floor rounding of a negative product.
    clear_pkt();
    add_beat(int'(32'hFFFF_FFFF), 32'h0008_0000);
    sb.push_back(mk(32'hFFFF_FFFF, 1, 1'b0));
    send_pkt(0, qw, qx, 1'b0);

    // Positive overflow of the addition.
    clear_pkt();
    add_beat(32'h0010_0000, 32'h0020_0000);
`ifdef MAC_SAT_EN
    sb.push_back(mk(32'h7FFF_FFFF, 1, 1'b1));
`else
    sb.push_back(mk(32'h8010_0000, 1, 1'b0));
`endif
    send_pkt(32'h7FF0_0000, qw, qx, 1'b0);

    // Count cap on the LEN_W=2 instance.
    clear_pkt();
    repeat (5) add_beat(0, 0);
    sb.push_back(mk(32'h0010_0000, 5, 1'b0));
    send_pkt(32'h0010_0000, qw, qx, 1'b1);

    // Reset while the output is pending.
    @(posedge clk);
    #1;
    o_ready = 1'b0;
    clear_pkt();
    add_beat(32'h0010_0000, 32'h0010_0000);
    sb.push_back(mk(32'h0020_0000, 1, 1'b0));
    send_pkt(32'h0010_0000, qw, qx, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    do_reset("outreset");
    o_ready = 1'b1;

    // Long packet: 8-bit count saturates at 255.
    clear_pkt();
    repeat (260) add_beat(int'($urandom_range(0, 32'h0020_0000)) - 32'h0010_0000,
                          int'($urandom_range(0, 32'h0020_0000)) - 32'h0010_0000);
    bias = rnd_val();
    sb.push_back(model(bias, qw, qx));
    send_pkt(bias, qw, qx, 1'b0);

    // Random packets with random consumer backpressure.
    rdy_rand = 1'b1;
    for (int k = 0; k < 60; k++) begin
      clear_pkt();
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) add_beat(rnd_val(), rnd_val());
      bias = rnd_val();
      sb.push_back(model(bias, qw, qx));
      send_pkt(bias, qw, qx, 1'b1);
    end
    rdy_rand = 1'b0;

    for (int t = 0; t < 100 && sb.size() != 0; t++) begin
      @(posedge clk);
      #1;
      o_ready = 1'b1;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lstm_mac_acc.md
# lstm_mac_acc

Sequential multiply-accumulate stage that forms the pre-activation `sum(w*x) + bias` for one LSTM gate element in Q12.20 fixed point and hands it to the tanh/sigmoid activation stage directly downstream. It consumes one weight/input pair per accepted beat on a valid/ready stream. On the beat flagged last it presents the finished sum on a held output register and waits for the consumer to accept it. Each packet of beats produces exactly one pre-activation value.

## Interface
- `WIDTH`, 32, data width; signed two's complement Q(WIDTH-FRAC).FRAC.
- `FRAC`, 20, fraction bits; 1.0 = `0x00100000`.
- `LEN_W`, 8, width of the beat counter.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_w`  in  WIDTH  weight for this beat.
- `i_x`  in  WIDTH  input/hidden value for this beat.
- `i_bias`  in  WIDTH  bias; sampled only on the first beat of a packet.
- `i_last`  in  1  marks the final beat of a packet.
- `i_valid`  in  1  beat present.
- `i_ready`  out  1  block can accept a beat.
- `o_data`  out  WIDTH  finished pre-activation.
- `o_beats`  out  LEN_W  beats in the packet; saturates at all-ones.
- `o_sat`  out  1  saturation occurred in this packet (see Configuration).
- `o_valid`  out  1  `o_data`/`o_beats`/`o_sat` valid.
- `o_ready`  in  1  consumer accepts the output.

## Operation
- Beat accepted when `i_valid && i_ready`; output accepted when `o_valid && o_ready`.
- Two states:
  - S_ACC: `i_ready`=1, `o_valid`=0.
  - S_OUT: `i_ready`=0, `o_valid`=1.
- Internal registers: `acc` (WIDTH), `first` flag (1 after reset and after each output handoff), `cnt` (LEN_W).
- Product `p` = (signed `i_w` × signed `i_x`) as a 2·WIDTH-bit value, arithmetically shifted right by FRAC. Rounding is floor (toward −∞), then reduced to WIDTH bits.
- Accepted beat in S_ACC:
  - base = `first` ? `i_bias` : `acc`.
  - new = base + `p`.
  - `acc` <= new; `first` <= 0; `cnt` <= `first` ? 1 : min(`cnt`+1, all-ones).
- Accepted beat with `i_last`=1:
  - additionally loads `o_data` <= new, `o_beats` <= the updated count, `o_sat` <= sticky flag including this beat.
  - enters S_OUT.
- A single-beat packet (`first` and `i_last` on the same beat) outputs `i_bias` + `p`.
- S_OUT:
  - outputs held stable while `o_ready`=0.
  - on `o_ready`: return to S_ACC, `first` <= 1, `acc` <= 0, `cnt` <= 0, sticky flag cleared.
- `i_valid` while in S_OUT is ignored; no beat is consumed.

## Timing
- Reset values: state S_ACC, `i_ready`=1, `o_valid`=0, `o_data`=0, `o_beats`=0, `o_sat`=0, `acc`=0, `first`=1.
- Throughput: one beat per cycle in S_ACC.
- Latency: `o_valid` rises the cycle after the last beat is accepted.
- After output handoff, `i_ready` is 1 in the next cycle, so the minimum gap between packets is 1 cycle.
- `i_ready` depends only on state; there is no combinational path from `o_ready` to `i_ready`.
- `rst` asserted at any time, including mid-packet or in S_OUT, returns all registers to their reset values immediately; a partial packet is discarded.

## Configuration
- `MAC_SAT_EN` defined:
  - the shifted product and each addition clamp to `0x7FFFFFFF` / `0x80000000` for WIDTH=32 (max/min signed).
  - any clamp sets the packet's sticky flag, reported on `o_sat`.
- Not defined:
  - product truncation and addition wrap modulo 2^WIDTH.
  - `o_sat` is constant 0.

## Test plan
- Reset: assert `rst` mid-stream -> `o_valid`=0, `o_data`=0, `i_ready`=1. The next packet `bias=0x00040000`, one beat `w=0x00100000`, `x=0x00100000`, last -> `o_data=0x00140000`, `o_beats`=1.
- Two-beat sum: bias `0x00040000`; beats (`0x00080000`,`0x00200000`) then (`0x00100000`,`0xFFF00000`, last) -> `o_data=0x00040000`, `o_beats`=2, `o_valid` one cycle after the last beat.
- Backpressure: hold `o_ready`=0 for 5 cycles with `i_valid`=1 -> `i_ready`=0, output stable, no beat consumed. Then raise `o_ready` -> the next packet uses its own fresh bias.
- Floor rounding: bias 0, `w=0xFFFFFFFF`, `x=0x00080000`, last -> `o_data=0xFFFFFFFF`.
- Overflow: bias `0x7FF00000`, `w=0x00100000`, `x=0x00200000`, last:
  - with `MAC_SAT_EN` -> `o_data=0x7FFFFFFF`, `o_sat`=1.
  - without -> `o_data=0x80100000`, `o_sat`=0.
- Counter cap (`LEN_W`=2): 5-beat packet of `w=0`, `x=0`, bias `0x00100000` -> `o_beats`=3, `o_data=0x00100000`.
